// File: rtl/pipe_ctrl_pkg.sv
// Shared opcode constants, FSM state type and decode helper for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    typedef enum logic {
        RUN      = 1'b0,
        LU_STALL = 1'b1
    } haz_state_e;

    // Instructions whose rt field is a source operand (not a destination).
    function automatic logic op_reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_haz_cmp.sv
// Load-use hazard comparator: flags an ID instruction that reads the register an EX load is writing.
module haz_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    output logic       lu
);

    logic uses_rt;

    // $zero is never a real dependency, so ex_rt==0 cannot raise a hazard.
    always_comb begin
        uses_rt = op_reads_rt(id_opcode);
        lu      = ex_memread && (ex_rt != '0) &&
                  ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall FSM, branch flush, external freeze.
// Optional statistics counters are built when PIPE_HAZ_STATS_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_CYCLES = 1,
    parameter int STATS_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         id_opcode,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic               ex_memread,
    input  logic [4:0]         ex_rt,
    input  logic               mem_branch,
    input  logic               mem_zero,
    input  logic               ext_stall,
    output logic               pc_we,
    output logic               pc_src,
    output logic               ifid_we,
    output logic               ifid_flush,
    output logic               idex_bubble,
    output logic               exmem_flush,
    output logic               hold,
    output logic [STATS_W-1:0] stall_count,
    output logic [STATS_W-1:0] flush_count
);

    localparam int CNT_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    haz_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lu;
    logic             taken;

    haz_cmp u_haz_cmp (
        .id_opcode  (id_opcode),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .ex_memread (ex_memread),
        .ex_rt      (ex_rt),
        .lu         (lu)
    );

    assign taken = mem_branch & mem_zero;

    // State and remaining-stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and output decode; reset gates every output to 0 combinationally.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_we       = 1'b0;
        pc_src      = 1'b0;
        ifid_we     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        hold        = 1'b0;
        if (!rst_n) begin
            state_d = RUN;
            cnt_d   = '0;
        end else if (ext_stall) begin
            hold = 1'b1;
        end else if (taken) begin
            pc_we       = 1'b1;
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            state_d     = RUN;
            cnt_d       = '0;
        end else if (state_q == LU_STALL) begin
            idex_bubble = 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d = RUN;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (lu) begin
            idex_bubble = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_d = LU_STALL;
                cnt_d   = CNT_W'(STALL_CYCLES - 1);
            end
        end else begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
        end
    end

`ifdef PIPE_HAZ_STATS_EN
    logic [STATS_W-1:0] stall_cnt_q, flush_cnt_q;

    // Saturating stall/flush statistics; held cycles never count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (!hold) begin
            if (idex_bubble && !pc_src && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (pc_src && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + 1'b1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one instance with STALL_CYCLES=1, one with 3, shared stimulus.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int SW_ = 16;
`ifdef PIPE_HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // {pc_we, pc_src, ifid_we, ifid_flush, idex_bubble, exmem_flush, hold}
    localparam logic [6:0] O_ZERO = 7'b0000000;
    localparam logic [6:0] O_NORM = 7'b1010000;
    localparam logic [6:0] O_BUB  = 7'b0000100;
    localparam logic [6:0] O_TAKE = 7'b1101110;
    localparam logic [6:0] O_HOLD = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] id_opcode;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       ex_memread, mem_branch, mem_zero, ext_stall;

    logic pc_we1, pc_src1, ifid_we1, ifid_flush1, idex_bubble1, exmem_flush1, hold1;
    logic pc_we3, pc_src3, ifid_we3, ifid_flush3, idex_bubble3, exmem_flush3, hold3;
    logic [SW_-1:0] stall_count1, flush_count1, stall_count3, flush_count3;
    logic [6:0] o1, o3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.STALL_CYCLES(1), .STATS_W(SW_)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
        .ext_stall(ext_stall), .pc_we(pc_we1), .pc_src(pc_src1), .ifid_we(ifid_we1),
        .ifid_flush(ifid_flush1), .idex_bubble(idex_bubble1), .exmem_flush(exmem_flush1),
        .hold(hold1), .stall_count(stall_count1), .flush_count(flush_count1)
    );

    pipe_hazard_ctrl #(.STALL_CYCLES(3), .STATS_W(SW_)) dut3 (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_branch(mem_branch), .mem_zero(mem_zero),
        .ext_stall(ext_stall), .pc_we(pc_we3), .pc_src(pc_src3), .ifid_we(ifid_we3),
        .ifid_flush(ifid_flush3), .idex_bubble(idex_bubble3), .exmem_flush(exmem_flush3),
        .hold(hold3), .stall_count(stall_count3), .flush_count(flush_count3)
    );

    assign o1 = {pc_we1, pc_src1, ifid_we1, ifid_flush1, idex_bubble1, exmem_flush1, hold1};
    assign o3 = {pc_we3, pc_src3, ifid_we3, ifid_flush3, idex_bubble3, exmem_flush3, hold3};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Check both instances at the negedge of the current cycle, then advance past the next posedge.
    task automatic cyc(input string tag, input logic [6:0] e1, input logic [6:0] e3);
        @(negedge clk);
        chk({tag, "/sc1"}, 32'(o1), 32'(e1));
        chk({tag, "/sc3"}, 32'(o3), 32'(e3));
        @(posedge clk);
        #1;
    endtask

    task automatic stats(input string tag, input int s1, input int f1, input int s3, input int f3);
        chk({tag, "/stall1"}, 32'(stall_count1), STATS ? 32'(s1) : 32'd0);
        chk({tag, "/flush1"}, 32'(flush_count1), STATS ? 32'(f1) : 32'd0);
        chk({tag, "/stall3"}, 32'(stall_count3), STATS ? 32'(s3) : 32'd0);
        chk({tag, "/flush3"}, 32'(flush_count3), STATS ? 32'(f3) : 32'd0);
    endtask

    task automatic idle();
        id_opcode  = OP_RTYPE;
        id_rs      = 5'd1;
        id_rt      = 5'd2;
        ex_memread = 1'b0;
        ex_rt      = 5'd0;
        mem_branch = 1'b0;
        mem_zero   = 1'b0;
        ext_stall  = 1'b0;
    endtask

    task automatic load_use_rtype();
        ex_memread = 1'b1;
        ex_rt      = 5'd8;
        id_opcode  = OP_RTYPE;
        id_rs      = 5'd3;
        id_rt      = 5'd8;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;

        // 1: reset outputs, then normal flow
        cyc("rst_a", O_ZERO, O_ZERO);
        cyc("rst_b", O_ZERO, O_ZERO);
        stats("rst", 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc("run0", O_NORM, O_NORM);

        // 2: load-use on rt; 1 bubble vs 3 bubbles
        load_use_rtype();
        cyc("lu_c1", O_BUB, O_BUB);
        idle();
        cyc("lu_c2", O_NORM, O_BUB);
        cyc("lu_c3", O_NORM, O_BUB);
        cyc("lu_end", O_NORM, O_NORM);
        stats("lu", 1, 0, 3, 0);

        // 3: taken branch on 2nd stall cycle
        load_use_rtype();
        cyc("tk_c1", O_BUB, O_BUB);
        idle();
        mem_branch = 1'b1;
        mem_zero   = 1'b1;
        cyc("tk_c2", O_TAKE, O_TAKE);
        idle();
        cyc("tk_run", O_NORM, O_NORM);
        stats("tk", 2, 1, 4, 1);

        // 4: $zero never stalls; LW rt is not a source; SW rt is
        ex_memread = 1'b1;
        ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_opcode = OP_RTYPE;
        cyc("zero", O_NORM, O_NORM);
        ex_rt = 5'd9; id_rs = 5'd4; id_rt = 5'd9; id_opcode = OP_LW;
        cyc("lw_rt", O_NORM, O_NORM);
        id_opcode = OP_SW;
        cyc("sw_rt", O_BUB, O_BUB);
        idle();
        cyc("sw_c2", O_NORM, O_BUB);
        cyc("sw_c3", O_NORM, O_BUB);
        cyc("sw_end", O_NORM, O_NORM);

        // 5: lu and taken together, flush wins
        load_use_rtype();
        mem_branch = 1'b1;
        mem_zero   = 1'b1;
        cyc("lu_tk", O_TAKE, O_TAKE);
        idle();
        cyc("lu_tk_after", O_NORM, O_NORM);
        stats("lutk", 3, 2, 7, 2);

        // 6: ext_stall freezes mid-stall, then the stall resumes
        load_use_rtype();
        cyc("hs_c1", O_BUB, O_BUB);
        idle();
        ext_stall = 1'b1;
        for (int unsigned i = 0; i < 4; i++) cyc("hs_hold", O_HOLD, O_HOLD);
        ext_stall = 1'b0;
        cyc("hs_c2", O_NORM, O_BUB);
        cyc("hs_c3", O_NORM, O_BUB);
        cyc("hs_end", O_NORM, O_NORM);
        // taken branch deferred under ext_stall
        ext_stall  = 1'b1;
        mem_branch = 1'b1;
        mem_zero   = 1'b1;
        cyc("dt_hold", O_HOLD, O_HOLD);
        ext_stall = 1'b0;
        cyc("dt_take", O_TAKE, O_TAKE);
        idle();
        cyc("dt_run", O_NORM, O_NORM);
        stats("hs", 4, 3, 10, 3);

        // reset pulse mid-stall: immediate zero outputs, no residual stall
        load_use_rtype();
        cyc("rs_c1", O_BUB, O_BUB);
        idle();
        rst_n = 1'b0;
        #1;
        chk("rs_now/sc1", 32'(o1), 32'(O_ZERO));
        chk("rs_now/sc3", 32'(o3), 32'(O_ZERO));
        stats("rs", 0, 0, 0, 0);
        cyc("rs_held", O_ZERO, O_ZERO);
        rst_n = 1'b1;
        cyc("rs_run", O_NORM, O_NORM);
        cyc("rs_run2", O_NORM, O_NORM);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
